// File: rtl/fu_mul_pkg.sv
// fu_mul_pkg: shared op and state encodings for the iterative multiplier
package fu_mul_pkg;
  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_H   = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HU  = 2'b11
  } mul_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mul_state_t;
endpackage

// File: rtl/fu_mul_iter_if.sv
// fu_mul_iter_if: issue-side request/result bundle of the iterative multiplier
interface fu_mul_iter_if #(parameter int WIDTH = 32);
  import fu_mul_pkg::*;
  logic             EN;
  mul_op_t          op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] res;
  logic             finish;
  logic             busy;
  modport master (output EN, op, A, B, input res, finish, busy);
  modport slave  (input EN, op, A, B, output res, finish, busy);
endinterface

// File: rtl/mul_step.sv
// mul_step: one shift-and-add digit, acc_hi + mcand * digit, as STEP partial products
module mul_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]      acc_hi,
  input  logic [WIDTH-1:0]      mcand,
  input  logic [STEP-1:0]       digit,
  output logic [WIDTH+STEP-1:0] sum
);
  always_comb begin
    sum = {{STEP{1'b0}}, acc_hi};
    for (int i = 0; i < STEP; i++)
      sum = sum + (digit[i] ? ({{STEP{1'b0}}, mcand} << i) : '0);
  end
endmodule

// File: rtl/fu_mul_iter.sv
// fu_mul_iter: iterative signed/unsigned multiplier retiring STEP multiplier bits per cycle
module fu_mul_iter
  import fu_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic         clk,
  input logic         rst_n,
  fu_mul_iter_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N) + 1;
  mul_state_t          state;
  mul_op_t             op_q;
  logic                neg;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mplier;
  logic [2*WIDTH-1:0]  acc;
  logic [CW-1:0]       count;
  logic [WIDTH+STEP-1:0] sum;
  logic [2*WIDTH-1:0]  prod;
  logic                sa;
  logic                sb;
  // operands are reduced to magnitudes up front so the datapath is purely unsigned
  assign sa   = (bus.op == MUL_H || bus.op == MUL_HSU) && bus.A[WIDTH-1];
  assign sb   = bus.op == MUL_H && bus.B[WIDTH-1];
  assign prod = neg ? -acc : acc;
  mul_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .acc_hi(acc[2*WIDTH-1:WIDTH]),
    .mcand (mcand),
    .digit (mplier[STEP-1:0]),
    .sum   (sum)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= MUL_LO;
      neg        <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      bus.res    <= '0;
      bus.finish <= 1'b0;
      bus.busy   <= 1'b0;
    end else
      case (state)
        IDLE: begin
          bus.finish <= 1'b0;
          if (bus.EN) begin
            op_q     <= bus.op;
            neg      <= sa ^ sb;
            mcand    <= sa ? -bus.A : bus.A;
            mplier   <= sb ? -bus.B : bus.B;
            acc      <= '0;
            count    <= CW'(N - 1);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc    <= {sum, acc[WIDTH-1:STEP]};
          mplier <= mplier >> STEP;
          count  <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          bus.res    <= op_q == MUL_LO ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          bus.finish <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fu_mul_iter.sv
// tb_fu_mul_iter: vector table, random ops vs arithmetic model, and timing corner cases for STEP=1 and STEP=4
module tb_fu_mul_iter;
  import fu_mul_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fu_mul_iter_if #(.WIDTH(32)) b1 ();
  fu_mul_iter_if #(.WIDTH(32)) b4 ();
  fu_mul_iter #(.WIDTH(32), .STEP(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  fu_mul_iter #(.WIDTH(32), .STEP(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [65:0] x, y, p;
    x = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    y = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p = x * y;
    return op == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(int w, logic en, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (w == 1) begin
      b1.EN = en; b1.op = mul_op_t'(op); b1.A = a; b1.B = b;
    end else begin
      b4.EN = en; b4.op = mul_op_t'(op); b4.A = a; b4.B = b;
    end
  endtask

  function automatic logic fin(int w);
    return w == 1 ? b1.finish : b4.finish;
  endfunction
  function automatic logic bsy(int w);
    return w == 1 ? b1.busy : b4.busy;
  endfunction
  function automatic logic [31:0] rs(int w);
    return w == 1 ? b1.res : b4.res;
  endfunction

  // one operation: checks result, finish cycle (N+2) and busy over cycles 1..N+2
  task automatic run(string name, int w, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    int n;
    int lat;
    int bad;
    n = w == 1 ? 32 : 8;
    lat = 0;
    bad = 0;
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    #1 drive(w, 1'b0, 2'($urandom), $urandom, $urandom);
    for (int c = 1; c <= n + 6 && lat == 0; c++) begin
      @(negedge clk);
      if (bsy(w) !== (c <= n + 1)) bad++;
      if (fin(w) === 1'b1) begin
        lat = c;
        chk({name, " res"}, rs(w), exp);
      end
    end
    chk({name, " latency"}, lat, n + 2);
    chk({name, " busy"}, bad, 0);
  endtask

  initial begin
    logic [31:0] a, b, e;
    logic [1:0] op;
    int fins, badpos, lat;
    vecs[0] = '{2'b00, 32'd7,        32'd6,        32'd42};
    vecs[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF};
    vecs[3] = '{2'b00, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB};
    vecs[4] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[6] = '{2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000};
    vecs[7] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[8] = '{2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[9] = '{2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E};
    drive(1, 1'b0, 2'b00, '0, '0);
    drive(4, 1'b0, 2'b00, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset res s1", b1.res, 32'h0);
    chk("reset finish s1", {31'b0, b1.finish}, 32'h0);
    chk("reset busy s1", {31'b0, b1.busy}, 32'h0);
    chk("reset res s4", b4.res, 32'h0);
    chk("reset finish s4", {31'b0, b4.finish}, 32'h0);
    chk("reset busy s4", {31'b0, b4.busy}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run($sformatf("vec%0d s1", i), 1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      run($sformatf("vec%0d s4", i), 4, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    for (int i = 0; i < 36; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      run($sformatf("rand%0d", i), i < 6 ? 1 : 4, op, a, b, model(op, a, b));
    end
    // EN held high: a new op is accepted in every finish cycle
    a = 32'hDEADBEEF;
    b = 32'hCAFEF00D;
    e = model(2'b11, a, b);
    fins = 0;
    badpos = 0;
    @(negedge clk);
    drive(4, 1'b1, 2'b11, a, b);
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (b4.finish === 1'b1) begin
        fins++;
        if (c % 10 != 0) badpos++;
        chk("b2b res", b4.res, e);
      end
      if (c == 31) b4.EN = 1'b0;
    end
    chk("b2b finishes", fins, 4);
    chk("b2b positions", badpos, 0);
    // starts while busy must be dropped
    a = 32'h00012345;
    b = 32'h00000777;
    e = model(2'b00, a, b);
    fins = 0;
    lat = 0;
    @(negedge clk);
    drive(4, 1'b1, 2'b00, a, b);
    @(posedge clk);
    #1 drive(4, 1'b0, 2'b01, 32'h55555555, 32'hAAAAAAAA);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (b4.finish === 1'b1) begin
        fins++;
        lat = c;
        chk("ignored res", b4.res, e);
      end
      b4.EN = (c >= 2 && c <= 8 && c % 2 == 0);
      b4.A = $urandom;
      b4.B = $urandom;
    end
    chk("ignored finishes", fins, 1);
    chk("ignored latency", lat, 10);
    // reset mid-operation on the STEP=1 unit
    run("pre-rst", 1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    @(negedge clk);
    drive(1, 1'b1, 2'b11, 32'h87654321, 32'h13579BDF);
    @(posedge clk);
    #1 drive(1, 1'b0, 2'b00, '0, '0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst res", b1.res, 32'h0);
    chk("midrst finish", {31'b0, b1.finish}, 32'h0);
    chk("midrst busy", {31'b0, b1.busy}, 32'h0);
    #2 rst_n = 1'b1;
    run("post-rst", 1, 2'b11, 32'h87654321, 32'h13579BDF, model(2'b11, 32'h87654321, 32'h13579BDF));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
